// File: rtl/lock_pkg.sv
// Shared encodings and defaults for the colour-combination lock and its output decode.
package lock_pkg;

   typedef enum logic [3:0] {
      ST_IDLE          = 4'd0,
      ST_ONE_CORRECT   = 4'd1,
      ST_TWO_CORRECT   = 4'd2,
      ST_THREE_CORRECT = 4'd3,
      ST_FOUR_CORRECT  = 4'd4,
      ST_ONE_WRONG     = 4'd5,
      ST_TWO_WRONG     = 4'd6,
      ST_THREE_WRONG   = 4'd7,
      ST_FOUR_WRONG    = 4'd8,
      ST_PROGRAM_MODE  = 4'd9,
      ST_ONE_SET       = 4'd10,
      ST_TWO_SET       = 4'd11,
      ST_THREE_SET     = 4'd12,
      ST_FOUR_SET      = 4'd13
   } state_e;

   typedef enum logic [1:0] {
      COL_RED    = 2'd0,
      COL_YELLOW = 2'd1,
      COL_GREEN  = 2'd2,
      COL_BLUE   = 2'd3
   } color_e;

   localparam logic [31:0] TIMEOUT_CYCLES_DEF = 32'd100_000_000;
   localparam logic [31:0] LOCKOUT_CYCLES_DEF = 32'd500_000_000;

   function automatic logic [1:0] code_digit(input logic [7:0] code, input logic [1:0] k);
      return code[{k, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/idle_timer.sv
// 32-bit up-counter with synchronous clear and enable; tc_o flags the count TC_VALUE-1.
module idle_timer #(
   parameter logic [31:0] TC_VALUE = 32'd2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic tc_o
);

   logic [31:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign tc_o = (cnt_q == (TC_VALUE - 32'd1));

endmodule

// File: rtl/lock_fsm_state.sv
// Four-colour combination lock: entry, program mode and idle timeout.
// Optional retry lockout is built only when LOCK_LOCKOUT_EN is defined.
//
// state            | meaning
// IDLE             | waiting for the first digit
// ONE..FOUR_CORRECT| k digits entered, all matching so far
// ONE..FOUR_WRONG  | k digits entered, at least one mismatch
// PROGRAM_MODE     | unlocked, program requested
// ONE..FOUR_SET    | k digits entered in program mode; FOUR_SET lasts one cycle
module lock_fsm_state
   import lock_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [31:0] LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] color_in,
   input  logic       color_valid,
   input  logic       program_btn,
   input  logic [7:0] code,
   output logic [3:0] state,
   output logic [1:0] last_color,
   output logic       locked
);

   state_e     state_q, state_d;
   logic [1:0] last_color_q;
   logic       press;
   logic       tmr_en, tmr_clr, tmr_tc, timeout;
   logic       lock_active, lock_done;

   assign press   = color_valid && !lock_active;
   assign tmr_en  = (state_q != ST_IDLE) && !lock_active;
   assign tmr_clr = press || (state_d != state_q);
   assign timeout = tmr_tc && tmr_en;

   idle_timer #(.TC_VALUE(TIMEOUT_CYCLES)) u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .clear_i (tmr_clr),
      .en_i    (tmr_en),
      .tc_o    (tmr_tc)
   );

   // Priority: bad encoding, lockout, FOUR_SET exit, program, press, timeout.
   always_comb begin
      state_d = state_q;
      if (4'(state_q) > 4'(ST_FOUR_SET)) begin
         state_d = ST_IDLE;
      end else if (lock_active) begin
         if (lock_done) state_d = ST_IDLE;
      end else if (state_q == ST_FOUR_SET) begin
         state_d = ST_IDLE;
      end else if (program_btn && (state_q == ST_FOUR_CORRECT)) begin
         state_d = ST_PROGRAM_MODE;
      end else if (press) begin
         case (state_q)
            ST_IDLE, ST_FOUR_CORRECT, ST_FOUR_WRONG:
               state_d = (color_in == code_digit(code, 2'd0)) ? ST_ONE_CORRECT : ST_ONE_WRONG;
            ST_ONE_CORRECT:
               state_d = (color_in == code_digit(code, 2'd1)) ? ST_TWO_CORRECT : ST_TWO_WRONG;
            ST_TWO_CORRECT:
               state_d = (color_in == code_digit(code, 2'd2)) ? ST_THREE_CORRECT : ST_THREE_WRONG;
            ST_THREE_CORRECT:
               state_d = (color_in == code_digit(code, 2'd3)) ? ST_FOUR_CORRECT : ST_FOUR_WRONG;
            ST_ONE_WRONG:    state_d = ST_TWO_WRONG;
            ST_TWO_WRONG:    state_d = ST_THREE_WRONG;
            ST_THREE_WRONG:  state_d = ST_FOUR_WRONG;
            ST_PROGRAM_MODE: state_d = ST_ONE_SET;
            ST_ONE_SET:      state_d = ST_TWO_SET;
            ST_TWO_SET:      state_d = ST_THREE_SET;
            ST_THREE_SET:    state_d = ST_FOUR_SET;
            default:         state_d = ST_IDLE;
         endcase
      end else if (timeout) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_color_q <= COL_RED;
      end else begin
         state_q <= state_d;
         if (press) last_color_q <= color_in;
      end
   end

`ifdef LOCK_LOCKOUT_EN
   logic [1:0] fail_q;
   logic       locked_q;
   logic       lock_tc;
   logic       enter_wrong, enter_correct;

   assign enter_wrong   = (state_d == ST_FOUR_WRONG)   && (state_q != ST_FOUR_WRONG);
   assign enter_correct = (state_d == ST_FOUR_CORRECT) && (state_q != ST_FOUR_CORRECT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_q   <= 2'd0;
         locked_q <= 1'b0;
      end else if (locked_q) begin
         if (lock_tc) begin
            locked_q <= 1'b0;
            fail_q   <= 2'd0;
         end
      end else if (enter_wrong) begin
         if (fail_q == 2'd2) begin
            locked_q <= 1'b1;
            fail_q   <= 2'd3;
         end else begin
            fail_q <= fail_q + 2'd1;
         end
      end else if (enter_correct) begin
         fail_q <= 2'd0;
      end
   end

   // Held clear while unlocked so each lockout starts from zero.
   idle_timer #(.TC_VALUE(LOCKOUT_CYCLES)) u_lockout_timer (
      .clk     (clk),
      .rst     (rst),
      .clear_i (!locked_q),
      .en_i    (locked_q),
      .tc_o    (lock_tc)
   );

   assign lock_active = locked_q;
   assign lock_done   = lock_tc;
`else
   assign lock_active = 1'b0;
   assign lock_done   = 1'b0 & (LOCKOUT_CYCLES == 32'd0);
`endif

   assign state      = state_q;
   assign last_color = last_color_q;
   assign locked     = lock_active;

endmodule

// File: tb/tb_lock_fsm_state.sv
// Scoreboard bench for lock_fsm_state: abstract attempt model feeds a queue, a monitor checks every cycle.
module tb_lock_fsm_state;

   localparam int T = 16;
   localparam int L = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] color_in;
   logic       color_valid;
   logic       program_btn;
   logic [7:0] code;
   logic [3:0] state;
   logic [1:0] last_color;
   logic       locked;

   always #5 clk = ~clk;

   lock_fsm_state #(.TIMEOUT_CYCLES(32'd16), .LOCKOUT_CYCLES(32'd8)) dut (
      .clk         (clk),
      .rst         (rst),
      .color_in    (color_in),
      .color_valid (color_valid),
      .program_btn (program_btn),
      .code        (code),
      .state       (state),
      .last_color  (last_color),
      .locked      (locked)
   );

   typedef struct {
      logic [3:0] st;
      logic [1:0] lc;
      logic       lk;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

`ifdef LOCK_LOCKOUT_EN
   bit lockout_en = 1'b1;
`else
   bit lockout_en = 1'b0;
`endif

   // Model: mode 0 idle, 1 entering code, 2 programming; n digits so far; ok = all matched.
   int         m_mode, m_n, m_icnt, m_fails, m_lock_left;
   bit         m_ok;
   logic [1:0] m_lc;

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
      end
   endtask

   function automatic logic [1:0] m_digit(int k);
      return 2'(code >> (2 * k));
   endfunction

   function automatic logic [3:0] m_enc();
      if (m_mode == 0) return 4'd0;
      if (m_mode == 2) return 4'(9 + m_n);
      return m_ok ? 4'(m_n) : 4'(4 + m_n);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_n = 0; m_ok = 1'b1; m_icnt = 0;
      m_fails = 0; m_lock_left = 0; m_lc = 2'd0;
   endtask

   task automatic model_step(bit p, logic [1:0] c, bit pb);
      logic [3:0] old;
      bit was_lock, acc, tmo;
      old      = m_enc();
      was_lock = (m_lock_left > 0);
      acc      = p && !was_lock;
      tmo      = (m_mode != 0) && !was_lock && (m_icnt == T - 1);
      if (was_lock) begin
         m_lock_left--;
         if (m_lock_left == 0) begin m_mode = 0; m_fails = 0; end
      end else if (m_mode == 2 && m_n == 4) begin
         m_mode = 0;
      end else if (pb && m_mode == 1 && m_n == 4 && m_ok) begin
         m_mode = 2; m_n = 0;
      end else if (acc) begin
         if (m_mode == 2) begin
            m_n++;
         end else begin
            if (m_mode == 0 || m_n == 4) begin m_mode = 1; m_n = 0; m_ok = 1'b1; end
            m_ok = m_ok && (c == m_digit(m_n));
            m_n++;
            if (m_n == 4) begin
               if (m_ok) m_fails = 0;
               else begin
                  m_fails++;
                  if (lockout_en && m_fails == 3) m_lock_left = L;
               end
            end
         end
      end else if (tmo) begin
         m_mode = 0;
      end
      if (acc) m_lc = c;
      if (acc || m_enc() != old) m_icnt = 0;
      else if (old != 4'd0 && !was_lock) m_icnt++;
   endtask

   // Called at a falling edge: drive one cycle of inputs and queue the post-edge expectation.
   task automatic step(bit p, logic [1:0] c, bit pb);
      exp_t e;
      color_valid = p;
      color_in    = c;
      program_btn = pb;
      model_step(p, c, pb);
      e.st = m_enc();
      e.lc = m_lc;
      e.lk = (m_lock_left > 0);
      q.push_back(e);
      @(negedge clk);
      color_valid = 1'b0;
      program_btn = 1'b0;
   endtask

   task automatic press(logic [1:0] c);
      step(1'b1, c, 1'b0);
   endtask

   task automatic idle(int k);
      for (int i = 0; i < k; i++) step(1'b0, 2'(i), 1'b0);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("state", 32'(state), 32'(e.st));
         check("last_color", 32'(last_color), 32'(e.lc));
         check("locked", 32'(locked), 32'(e.lk));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t got=running expected=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      color_in = 2'd0; color_valid = 1'b0; program_btn = 1'b0;
      code = 8'b11100100;
      model_reset();
      @(negedge clk);
      check("reset_state", 32'(state), 32'd0);
      check("reset_last_color", 32'(last_color), 32'd0);
      check("reset_locked", 32'(locked), 32'd0);
      rst = 1'b0;

      press(2'd0); press(2'd1); press(2'd2); press(2'd3);
      step(1'b1, 2'd1, 1'b1);
      press(2'd0); press(2'd1); press(2'd2); press(2'd3);
      idle(2);

      press(2'd0); press(2'd2); press(2'd3); press(2'd1);
      idle(3);

      press(2'd0); press(2'd1);
      idle(16);

      press(2'd0); press(2'd1);
      idle(15);
      press(2'd2);
      idle(2);

      press(2'd0); press(2'd1); press(2'd2); press(2'd3);
      step(1'b0, 2'd0, 1'b1);
      press(2'd3); press(2'd2); press(2'd1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_state", 32'(state), 32'd0);
      check("async_reset_last_color", 32'(last_color), 32'd0);
      #1 rst = 1'b0;
      model_reset();
      press(2'd0);
      idle(1);

      for (int a = 0; a < 3; a++) begin
         press(2'd1); press(2'd1); press(2'd1); press(2'd1);
      end
      for (int i = 0; i < 6; i++) press(2'd0);
      idle(20);

      for (int i = 0; i < 3000; i++) begin
         bit p, pb;
         logic [1:0] c;
         if ($urandom_range(0, 49) == 0) code = 8'($urandom);
         if ($urandom_range(0, 59) == 0) idle(int'($urandom_range(14, 20)));
         p  = ($urandom_range(0, 2) == 0);
         pb = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) != 0)
            c = m_digit((m_mode == 1 && m_n < 4) ? m_n : 0);
         else
            c = 2'($urandom);
         step(p, c, pb);
      end

      idle(2);
      @(posedge clk);
      #2;
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
